// File: rtl/usb_mac_pkg.sv
// usb_mac_pkg: shared constants, the transmit state type and the byte-wide
// LFSR step used by both the transmit scrambler and the receive descrambler.
//
// Contents:
//   K28_5, K28_1   - COM and SKP K-symbol codes
//   LFSR_SEED      - value loaded on reset, on COM and on leaving electrical idle
//   LFSR_TAPS      - Galois feedback mask for X^16+X^5+X^4+X^3+1
//   tx_state_t     - transmit FSM states
//   lfsr_adv8()    - advances the LFSR by 8 bits and scrambles one byte
package usb_mac_pkg;

    localparam logic [7:0]  K28_5     = 8'hBC;
    localparam logic [7:0]  K28_1     = 8'h3C;
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    localparam logic [15:0] LFSR_TAPS = 16'h0039;

    typedef enum logic [1:0] {
        ELEC   = 2'd0,
        ACTIVE = 2'd1,
        SKP1   = 2'd2,
        SKP2   = 2'd3
    } tx_state_t;

    // Returns {next_lfsr, scrambled_byte}. Bit 0 of the byte is scrambled
    // first, using lfsr[15] of the current state, then the LFSR steps once
    // per bit.
    function automatic logic [23:0] lfsr_adv8(input logic [15:0] lfsr,
                                              input logic [7:0]  data);
        logic [15:0] l;
        logic [7:0]  b;
        l = lfsr;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b[i] = data[i] ^ l[15];
            l    = {l[14:0], 1'b0} ^ (l[15] ? LFSR_TAPS : 16'h0000);
        end
        return {l, b};
    endfunction

endpackage

// File: rtl/usb_mac_tx_if.sv
// usb_mac_tx_if: link-layer symbol handshake into the transmit engine.
//
// Signals:
//   LNK_DATA  - symbol byte
//   LNK_DATAK - 1 = LNK_DATA is a K symbol
//   LNK_VALID - symbol offered by the link layer
//   LNK_READY - symbol taken when VALID and READY are high at the edge
// Modports: master = link layer (symbol source), slave = transmit engine.
interface usb_mac_tx_if;
    import usb_mac_pkg::*;

    logic [7:0] LNK_DATA;
    logic       LNK_DATAK;
    logic       LNK_VALID;
    logic       LNK_READY;

    modport master (
        output LNK_DATA,
        output LNK_DATAK,
        output LNK_VALID,
        input  LNK_READY
    );

    modport slave (
        input  LNK_DATA,
        input  LNK_DATAK,
        input  LNK_VALID,
        output LNK_READY
    );

endinterface

// File: rtl/usb_scrambler.sv
// usb_scrambler: USB 3.0 data scrambler/descrambler (16-bit Galois LFSR).
// Same block serves transmit and receive, since XOR is its own inverse.
//
// Ports:
//   clk      - clock, rising edge
//   srst     - synchronous active-high reset (LFSR <- seed)
//   init_i   - reload seed (COM seen); wins over advance_i
//   advance_i- step the LFSR by 8 bits
//   en_i     - 1 = XOR data with the LFSR output, 0 = pass through
//   data_i   - byte to scramble
//   data_o   - combinational result for the current LFSR state
module usb_scrambler
    import usb_mac_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       init_i,
    input  logic       advance_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [23:0] step;

    assign step = lfsr_adv8(lfsr_q, data_i);

    // The LFSR steps regardless of en_i so that toggling scrambling keeps
    // the sequence position aligned with the far end.
    assign data_o = en_i ? step[7:0] : data_i;

    always_comb begin
        lfsr_d = lfsr_q;
        if (init_i) begin
            lfsr_d = LFSR_SEED;
        end else if (advance_i) begin
            lfsr_d = step[23:8];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/usb_mac_tx.sv
// usb_mac_tx: PIPE transmit engine. Takes link-layer symbols, scrambles data
// bytes, fills gaps with scrambled logical idle (D0.0), inserts a SKP pair
// every SKP_INTERVAL symbols and drives electrical idle on request.
//
// Ports:
//   PHY_PCLK    - PIPE clock, rising edge
//   MAC_RST     - synchronous active-high reset
//   lnk         - symbol handshake (slave side)
//   LNK_IDLE    - request electrical idle
//   SCRAMBLE_EN - 1 = scramble data bytes
//   TX_DATA, TX_DATAK, TX_ELECIDLE - registered PHY outputs
//   SKP_SENT    - one-cycle pulse aligned with the second SKP symbol
module usb_mac_tx
    import usb_mac_pkg::*;
#(
    parameter int SKP_INTERVAL = 354
)
(
    input  logic               PHY_PCLK,
    input  logic               MAC_RST,
    usb_mac_tx_if.slave        lnk,
    input  logic               LNK_IDLE,
    input  logic               SCRAMBLE_EN,
    output logic [7:0]         TX_DATA,
    output logic               TX_DATAK,
    output logic               TX_ELECIDLE,
    output logic               SKP_SENT
);

    localparam int CNT_W = $clog2(SKP_INTERVAL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_datak_q, tx_datak_d;
    logic             tx_elecidle_q, tx_elecidle_d;
    logic             skp_sent_q, skp_sent_d;

    logic             scr_init;
    logic             scr_adv;
    logic [7:0]       scr_in;
    logic [7:0]       scr_out;

    usb_scrambler u_scrambler (
        .clk       (PHY_PCLK),
        .srst      (MAC_RST),
        .init_i    (scr_init),
        .advance_i (scr_adv),
        .en_i      (SCRAMBLE_EN),
        .data_i    (scr_in),
        .data_o    (scr_out)
    );

    assign lnk.LNK_READY = (state_q == ACTIVE);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_data_d     = 8'h00;
        tx_datak_d    = 1'b0;
        tx_elecidle_d = 1'b0;
        skp_sent_d    = 1'b0;
        scr_init      = 1'b0;
        scr_adv       = 1'b0;
        scr_in        = 8'h00;

        case (state_q)
            ELEC: begin
                tx_elecidle_d = 1'b1;
                if (!LNK_IDLE) begin
                    state_d  = ACTIVE;
                    cnt_d    = '0;
                    scr_init = 1'b1;
                end
            end

            ACTIVE: begin
                // A due SKP takes precedence over an idle request; the
                // request is still honoured once the pair has gone out.
                if (LNK_IDLE && !lnk.LNK_VALID && (cnt_q != CNT_LAST)) begin
                    state_d       = ELEC;
                    tx_elecidle_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = SKP1;
                    end
                    if (lnk.LNK_VALID && lnk.LNK_DATAK) begin
                        tx_data_d  = lnk.LNK_DATA;
                        tx_datak_d = 1'b1;
                        if (lnk.LNK_DATA == K28_5) begin
                            scr_init = 1'b1;
                        end else begin
                            scr_adv = 1'b1;
                        end
                    end else begin
                        // Data byte, or D0.0 logical idle when nothing offered.
                        scr_in    = lnk.LNK_VALID ? lnk.LNK_DATA : 8'h00;
                        tx_data_d = scr_out;
                        scr_adv   = 1'b1;
                    end
                end
            end

            SKP1: begin
                tx_data_d  = K28_1;
                tx_datak_d = 1'b1;
                state_d    = SKP2;
            end

            SKP2: begin
                tx_data_d  = K28_1;
                tx_datak_d = 1'b1;
                skp_sent_d = 1'b1;
                cnt_d      = '0;
                state_d    = ACTIVE;
            end

            default: begin
                state_d = ELEC;
            end
        endcase
    end

    always_ff @(posedge PHY_PCLK) begin
        if (MAC_RST) begin
            state_q       <= ELEC;
            cnt_q         <= '0;
            tx_data_q     <= 8'h00;
            tx_datak_q    <= 1'b0;
            tx_elecidle_q <= 1'b1;
            skp_sent_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            tx_datak_q    <= tx_datak_d;
            tx_elecidle_q <= tx_elecidle_d;
            skp_sent_q    <= skp_sent_d;
        end
    end

    assign TX_DATA     = tx_data_q;
    assign TX_DATAK    = tx_datak_q;
    assign TX_ELECIDLE = tx_elecidle_q;
    assign SKP_SENT    = skp_sent_q;

endmodule

// File: tb/tb_usb_mac_tx.sv
// tb_usb_mac_tx: directed test of usb_mac_tx with SKP_INTERVAL = 8.
module tb_usb_mac_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       idle;
    logic       scr_en;
    logic [7:0] tx_data;
    logic       tx_datak;
    logic       tx_elecidle;
    logic       skp_sent;

    int checks   = 0;
    int failures = 0;

    // USB 3.0 scrambler output for sixteen 00 bytes after a COM.
    logic [7:0] scr_tbl [16] = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82,
                                 8'h72, 8'h6E, 8'h28, 8'hA6, 8'hBE, 8'h6D, 8'hBF, 8'h8D};

    usb_mac_tx_if lnk_if ();

    usb_mac_tx #(.SKP_INTERVAL(8)) dut (
        .PHY_PCLK    (clk),
        .MAC_RST     (rst),
        .lnk         (lnk_if.slave),
        .LNK_IDLE    (idle),
        .SCRAMBLE_EN (scr_en),
        .TX_DATA     (tx_data),
        .TX_DATAK    (tx_datak),
        .TX_ELECIDLE (tx_elecidle),
        .SKP_SENT    (skp_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] d, input logic k,
                              input logic ei, input logic rdy, input logic skp);
        check({tag, "_data"}, {24'h0, tx_data}, {24'h0, d});
        check({tag, "_k"}, {31'h0, tx_datak}, {31'h0, k});
        check({tag, "_elecidle"}, {31'h0, tx_elecidle}, {31'h0, ei});
        check({tag, "_ready"}, {31'h0, lnk_if.LNK_READY}, {31'h0, rdy});
        check({tag, "_skp_sent"}, {31'h0, skp_sent}, {31'h0, skp});
    endtask

    // Offer a symbol, wait (bounded) until it is accepted, then check the
    // emitted symbol one cycle later. Called #1 after a rising edge.
    task automatic send(input string tag, input logic [7:0] d, input logic k,
                        input logic [7:0] exp_d, input logic exp_k);
        int n;
        lnk_if.LNK_DATA  = d;
        lnk_if.LNK_DATAK = k;
        lnk_if.LNK_VALID = 1'b1;
        n = 0;
        while (lnk_if.LNK_READY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_wait"}, {31'h0, lnk_if.LNK_READY}, 32'h1);
        tick();
        check({tag, "_data"}, {24'h0, tx_data}, {24'h0, exp_d});
        check({tag, "_k"}, {31'h0, tx_datak}, {31'h0, exp_k});
        check({tag, "_elecidle"}, {31'h0, tx_elecidle}, 32'h0);
        $display("send %s: in=%02h k=%0d -> TX_DATA=%02h TX_DATAK=%0d", tag, d, k, tx_data, tx_datak);
    endtask

    initial begin
        int n;
        rst              = 1'b1;
        idle             = 1'b1;
        scr_en           = 1'b1;
        lnk_if.LNK_DATA  = 8'h00;
        lnk_if.LNK_DATAK = 1'b0;
        lnk_if.LNK_VALID = 1'b0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs("reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        rst  = 1'b0;
        idle = 1'b0;

        // Scrambler sequence: COM then sixteen 00 bytes (SKPs interleave).
        send("com", 8'hBC, 1'b1, 8'hBC, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send($sformatf("scr%0d", i), 8'h00, 1'b0, scr_tbl[i], 1'b0);
        end

        // Electrical idle entry from ACTIVE with nothing offered.
        lnk_if.LNK_VALID = 1'b0;
        n = 0;
        while (lnk_if.LNK_READY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("idle_ready_wait", {31'h0, lnk_if.LNK_READY}, 32'h1);
        idle = 1'b1;
        tick();
        check_outs("elecidle", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        idle = 1'b0;
        send("nocom", 8'h00, 1'b0, 8'hFF, 1'b0);

        // Scrambling disabled, then re-enabled at the fourth data byte.
        scr_en = 1'b0;
        send("off_com", 8'hBC, 1'b1, 8'hBC, 1'b1);
        send("off0", 8'h00, 1'b0, 8'h00, 1'b0);
        send("off1", 8'h11, 1'b0, 8'h11, 1'b0);
        send("off2", 8'h22, 1'b0, 8'h22, 1'b0);
        scr_en = 1'b1;
        send("on3", 8'h55, 1'b0, 8'h41, 1'b0);

        // SKP insertion: COM at cnt 6, data at cnt 7, then SKP pair.
        send("skp_com", 8'hBC, 1'b1, 8'hBC, 1'b1);
        send("skp_d0", 8'h00, 1'b0, 8'hFF, 1'b0);
        check_outs("skp1", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("skp2", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("skp_done", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        check_outs("held", 8'h17, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 2; i < 9; i++) begin
            send($sformatf("run%0d", i), 8'h00, 1'b0, scr_tbl[i], 1'b0);
        end
        // Eight ACTIVE symbols since the last SKP: READY drops again.
        check("skp_again_ready", {31'h0, lnk_if.LNK_READY}, 32'h0);

        // Reset while in SKP1.
        rst = 1'b1;
        tick();
        check_outs("rst_skp", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        lnk_if.LNK_VALID = 1'b0;
        tick();
        check_outs("post_rst", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
